// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the decode-side instruction queue.
package ecap5_dproc_pkg;

    // Default number of queue entries
    localparam int unsigned IQ_DEPTH = 4;

    // One queued fetch: instruction word plus its PC
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: DEPTH entries, one write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the controller.
module inst_queue_mem
    import ecap5_dproc_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  iq_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output iq_entry_t       rdata_o
);

    iq_entry_t mem_q [DEPTH];

    // Write the addressed entry when enabled
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: pointers, occupancy and handshake control.
// Optional same-cycle fetch-to-decode bypass enabled by ECAP5_DPROC_IQ_BYPASS_EN.
module inst_queue
    import ecap5_dproc_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_valid_i,
    input  logic [31:0]            if_instr_i,
    input  logic [31:0]            if_pc_i,
    output logic                   if_ready_o,
    output logic                   dec_valid_o,
    output logic [31:0]            dec_instr_o,
    output logic [31:0]            dec_pc_o,
    input  logic                   dec_stall_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          empty, full, push, pop, wr_en;
    iq_entry_t     wr_entry, head;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LevelFull);
    assign wr_entry = '{instr: if_instr_i, pc: if_pc_i};

    // Ready ignores a same-cycle pop so a full queue never accepts
    assign if_ready_o = !full && !flush_i;
    assign push       = if_valid_i && if_ready_o;
    assign pop        = !empty && !flush_i && !dec_stall_i;

`ifdef ECAP5_DPROC_IQ_BYPASS_EN
    logic bypass;
    assign bypass      = empty && !flush_i && if_valid_i;
    assign dec_valid_o = (!empty && !flush_i) || bypass;
    assign dec_instr_o = bypass ? if_instr_i : head.instr;
    assign dec_pc_o    = bypass ? if_pc_i : head.pc;
    // A bypassed word consumed by decode this cycle is never stored
    assign wr_en       = push && !(bypass && !dec_stall_i);
`else
    assign dec_valid_o = !empty && !flush_i;
    assign dec_instr_o = head.instr;
    assign dec_pc_o    = head.pc;
    assign wr_en       = push;
`endif

    assign level_o = level_q;

    // Pointer and occupancy update; reset beats flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    inst_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: scoreboard of expected entries, checked at negedge.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        if_ready_o;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_stall_i;
    logic        flush_i;
    logic [$clog2(DEPTH):0] level_o;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_valid_i  (if_valid_i),
        .if_instr_i  (if_instr_i),
        .if_pc_i     (if_pc_i),
        .if_ready_o  (if_ready_o),
        .dec_valid_o (dec_valid_o),
        .dec_instr_o (dec_instr_o),
        .dec_pc_o    (dec_pc_o),
        .dec_stall_i (dec_stall_i),
        .flush_i     (flush_i),
        .level_o     (level_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check outputs at negedge, update the scoreboard
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic stall, input logic fl);
        bit          exp_valid, exp_ready, byp;
        logic [63:0] exp_head;
        if_valid_i  = v;
        if_instr_i  = ins;
        if_pc_i     = pc;
        dec_stall_i = stall;
        flush_i     = fl;
        @(negedge clk);
        exp_ready = (exp_q.size() != DEPTH) && !fl;
        exp_valid = (exp_q.size() != 0) && !fl;
        byp = 1'b0;
`ifdef ECAP5_DPROC_IQ_BYPASS_EN
        if (exp_q.size() == 0 && !fl && v) begin
            byp = 1'b1;
            exp_valid = 1'b1;
        end
`endif
        check("if_ready", 64'(if_ready_o), 64'(exp_ready));
        check("dec_valid", 64'(dec_valid_o), 64'(exp_valid));
        check("level", 64'(level_o), 64'(exp_q.size()));
        if (exp_valid) begin
            exp_head = byp ? {ins, pc} : exp_q[0];
            check("dec_instr", 64'(dec_instr_o), 64'(exp_head[63:32]));
            check("dec_pc", 64'(dec_pc_o), 64'(exp_head[31:0]));
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_valid && !stall && !byp) void'(exp_q.pop_front());
            if (v && exp_ready && !(byp && !stall)) exp_q.push_back({ins, pc});
        end
        @(posedge clk);
        #1;
    endtask

    // Reset with push and flush also asserted to exercise reset priority
    task automatic do_reset();
        rst_i       = 1'b1;
        if_valid_i  = 1'b1;
        if_instr_i  = 32'hBAD0_0000;
        if_pc_i     = 32'hFFFF_0000;
        flush_i     = 1'b1;
        dec_stall_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        flush_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst_i = 1'b1;
        if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
        dec_stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state, then single push and pop
        step(0, 0, 0, 0, 0);
        step(1, 32'h0000_0013, 32'h100, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Fill under stall, overflow attempt, then drain in order
        for (int i = 0; i < 4; i++) step(1, 32'hA000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1, 0);
        step(1, 32'hA000_00FF, 32'h2FC, 1, 0);
        step(1, 32'hA000_00FE, 32'h2F8, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        // Simultaneous push and pop at level 2 across pointer wrap
        step(1, 32'hB000_0000, 32'h300, 1, 0);
        step(1, 32'hB000_0001, 32'h304, 1, 0);
        for (int i = 2; i < 12; i++) step(1, 32'hB000_0000 + 32'(i), 32'h300 + 32'(4 * i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Flush at level 3 with a concurrent fetch
        for (int i = 0; i < 3; i++) step(1, 32'hC000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1, 0);
        step(1, 32'hC000_00FF, 32'h4FC, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset at level 2
        step(1, 32'hD000_0000, 32'h500, 1, 0);
        step(1, 32'hD000_0001, 32'h504, 1, 0);
        do_reset();
        step(0, 0, 0, 0, 0);

        // Empty-queue push with no stall (bypassed when enabled), then pop on empty
        step(1, 32'hDEAD_BEEF, 32'h600, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entry count; power of two, 2..16.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_valid_i  input  1  fetch presents an instruction.
REQ-005 SHALL have port if_instr_i  input  32  fetched instruction word.
REQ-006 SHALL have port if_pc_i  input  32  PC of the fetched instruction.
REQ-007 SHALL have port if_ready_o  output  1  queue accepts a push this cycle.
REQ-008 SHALL have port dec_valid_o  output  1  head entry is valid for decode.
REQ-009 SHALL have port dec_instr_o  output  32  head instruction word.
REQ-010 SHALL have port dec_pc_o  output  32  head PC.
REQ-011 SHALL have port dec_stall_i  input  1  decode stall, driven by the hazard unit's dec_stall_request_o.
REQ-012 SHALL have port flush_i  input  1  branch taken: discard all queued entries.
REQ-013 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL push when if_valid_i and if_ready_o are both high; word and PC are written at the write pointer.
REQ-015 SHALL pop when dec_valid_o is high and dec_stall_i is low; the read pointer advances.
REQ-016 SHALL drive if_ready_o = (level != DEPTH) and flush_i low, combinationally.
REQ-017 SHALL drive dec_valid_o = (level != 0) and flush_i low.
REQ-018 SHALL drive dec_instr_o/dec_pc_o from the head entry; values are don't-care while dec_valid_o is low.
REQ-019 SHALL hold dec_instr_o/dec_pc_o stable while dec_valid_o is high and dec_stall_i is high.
REQ-020 SHALL give 1-cycle latency: a word pushed in cycle N is first presented in cycle N+1.
REQ-021 SHALL update level: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-022 SHALL wrap pointers modulo DEPTH; full and empty are resolved by level, not by pointer equality.
REQ-023 SHALL refuse a push when full, even if a pop occurs in the same cycle (if_ready_o is not pop-aware).
REQ-024 SHALL, on flush_i, zero level and both pointers at the next edge; no push or pop takes effect in the flush cycle.
REQ-025 SHALL NOT let a pop on an empty queue change any state.

Reset
REQ-026 SHALL, on rst_i high at a rising edge, clear level and both pointers to 0.
REQ-027 SHALL drive if_ready_o=1, dec_valid_o=0 and level_o=0 in the cycle after reset.
REQ-028 SHALL treat reset during operation like flush_i: all entries are lost and storage contents are don't-care.
REQ-029 SHALL give rst_i priority over flush_i, push and pop.

Configuration
REQ-030 SHALL provide macro ECAP5_DPROC_IQ_BYPASS_EN, which controls a same-cycle bypass path.
REQ-031 With the macro defined, SHALL, when level=0, flush_i low and if_valid_i high, drive dec_valid_o=1 with if_instr_i/if_pc_i in the same cycle.
REQ-032 With the macro defined, SHALL NOT write the bypassed word if dec_stall_i is low in that cycle; if dec_stall_i is high, the word is written normally.
REQ-033 Without the macro, SHALL have no combinational path from if_* inputs to dec_* outputs, and REQ-020 applies unconditionally.

Structure
REQ-034 SHALL place the default depth constant IQ_DEPTH and the entry typedef iq_entry_t (instr[31:0], pc[31:0]) in ecap5_dproc_pkg.
REQ-035 SHALL implement storage as sub-module inst_queue_mem: DEPTH x 64-bit register file, one write port, one asynchronous read port, no reset.
REQ-036 SHALL keep pointer, level and control logic in inst_queue.

Verification
REQ-037 Push 0x00000013 @PC 0x100, dec_stall_i=0 -> next cycle dec_valid_o=1, instr 0x13, pc 0x100; following cycle level_o=0.
REQ-038 Push 4 words with dec_stall_i=1 (DEPTH=4) -> level_o=4, if_ready_o=0; 5th push ignored; release stall -> words popped in order, one per cycle.
REQ-039 With level=2, push and pop in the same cycle -> level_o stays 2; run 10 cycles to confirm pointer wrap preserves order.
REQ-040 With level=3, assert flush_i with if_valid_i=1 -> dec_valid_o=0 in that cycle, level_o=0 next cycle, flush-cycle word absent.
REQ-041 Pulse rst_i with level=2 -> next cycle level_o=0, dec_valid_o=0, if_ready_o=1.
REQ-042 With ECAP5_DPROC_IQ_BYPASS_EN and queue empty, push 0xDEADBEEF with dec_stall_i=0 -> same-cycle dec_valid_o=1, instr 0xDEADBEEF, level_o stays 0.
